// File: rtl/i2s_engine_port.sv
// i2s_engine_port: slave-mode I2S front end for dsp_engine_seq.
// Captures the ADC left slot and hands it to the engine with a sample_ready pulse.
// Waits for the engine's ready rising edge, then serialises the returned sample to the DAC in both slots.
// The codec pins are asynchronous and are synchronised into clk before any edge is taken.
// Optional build macro: I2S_PORT_COUNTERS_EN adds saturating overrun/underrun event counters.
module i2s_engine_port #(
    parameter int data_width = 16,
    parameter int slot_width = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bclk,
    input  logic                         lrclk,
    input  logic                         sdin,
    output logic                         sdout,
    output logic signed [data_width-1:0] in_sample,
    output logic                         sample_ready,
    input  logic        [data_width-1:0] out_sample,
    input  logic                         engine_ready,
    output logic                         overrun,
    output logic                         underrun,
`ifdef I2S_PORT_COUNTERS_EN
    output logic [15:0]                  overrun_count,
    output logic [15:0]                  underrun_count,
`endif
    input  logic                         clear_flags
);

    localparam int CW = $clog2(slot_width + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // [0],[1] form the 2-FF synchroniser, [2] holds the previous synchronised value for edges
    logic [2:0]            bclk_sync_q, bclk_sync_d;
    logic [2:0]            lrclk_sync_q, lrclk_sync_d;
    logic [1:0]            sdin_sync_q, sdin_sync_d;
    logic                  locked_q, locked_d;
    logic [CW-1:0]         bit_ctr_q, bit_ctr_d;
    logic [data_width-1:0] rx_sr_q, rx_sr_d;
    logic [data_width-1:0] in_sample_q, in_sample_d;
    logic                  sample_ready_q, sample_ready_d;
    logic [0:0]            state_q, state_d;
    logic                  ready_prev_q, ready_prev_d;
    logic [data_width-1:0] tx_hold_q, tx_hold_d;
    logic                  fresh_q, fresh_d;
    logic [slot_width-1:0] tx_sr_q, tx_sr_d;
    logic                  sdout_q, sdout_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
`ifdef I2S_PORT_COUNTERS_EN
    logic [15:0]           overrun_count_q, overrun_count_d;
    logic [15:0]           underrun_count_q, underrun_count_d;
`endif

    logic       bclk_rise, bclk_fall, lr_rise, lr_fall, lr_edge;
    logic       ready_rise, ret, issue, ovr_set, und_set;
    logic [0:0] state_after;

    // Next-state logic for the whole port: sync, framing, engine handshake, TX, flags
    always_comb begin
        bclk_sync_d    = {bclk_sync_q[1:0], bclk};
        lrclk_sync_d   = {lrclk_sync_q[1:0], lrclk};
        sdin_sync_d    = {sdin_sync_q[0], sdin};
        locked_d       = locked_q;
        bit_ctr_d      = bit_ctr_q;
        rx_sr_d        = rx_sr_q;
        in_sample_d    = in_sample_q;
        sample_ready_d = 1'b0;
        state_d        = state_q;
        ready_prev_d   = engine_ready;
        tx_hold_d      = tx_hold_q;
        fresh_d        = fresh_q;
        tx_sr_d        = tx_sr_q;
        sdout_d        = sdout_q;
        overrun_d      = overrun_q;
        underrun_d     = underrun_q;

        bclk_rise  = bclk_sync_q[1] & ~bclk_sync_q[2];
        bclk_fall  = ~bclk_sync_q[1] & bclk_sync_q[2];
        lr_rise    = lrclk_sync_q[1] & ~lrclk_sync_q[2];
        lr_fall    = ~lrclk_sync_q[1] & lrclk_sync_q[2];
        lr_edge    = lr_rise | lr_fall;
        ready_rise = engine_ready & ~ready_prev_q;

        // Engine return is resolved before issue so a coincident ready rise frees the slot
        ret         = (state_q == ST_BUSY) && ready_rise;
        state_after = ret ? ST_IDLE : state_q;
        issue       = lr_rise && locked_q && (state_after == ST_IDLE);
        ovr_set     = lr_rise && locked_q && (state_after == ST_BUSY);
        und_set     = lr_fall && locked_q && !(fresh_q || ret);

        if (lr_fall)
            locked_d = 1'b1;

        // RX framing: bit 0 is the I2S delay bit, bits 1..data_width are the sample
        if (lr_edge) begin
            bit_ctr_d = '0;
        end else if (bclk_rise) begin
            if (!lrclk_sync_q[1] && bit_ctr_q >= CW'(1) && bit_ctr_q <= CW'(data_width))
                rx_sr_d = {rx_sr_q[data_width-2:0], sdin_sync_q[1]};
            if (bit_ctr_q < CW'(slot_width))
                bit_ctr_d = bit_ctr_q + CW'(1);
        end

        if (ret) begin
            tx_hold_d = out_sample;
            fresh_d   = 1'b1;
        end
        if (lr_fall)
            fresh_d = 1'b0;

        state_d = state_after;
        if (issue) begin
            in_sample_d    = rx_sr_q;
            sample_ready_d = 1'b1;
            state_d        = ST_BUSY;
        end

        // TX: reload at every slot boundary, then one bit per BCLK falling edge once locked
        if (lr_edge) begin
            tx_sr_d = '0;
            tx_sr_d[slot_width-1 -: data_width] = tx_hold_d;
        end else if (bclk_fall && locked_q) begin
            sdout_d = tx_sr_q[slot_width-1];
            tx_sr_d = {tx_sr_q[slot_width-2:0], 1'b0};
        end

        // Sticky flags: a set event beats a clear in the same cycle
        if (ovr_set)
            overrun_d = 1'b1;
        else if (clear_flags)
            overrun_d = 1'b0;
        if (und_set)
            underrun_d = 1'b1;
        else if (clear_flags)
            underrun_d = 1'b0;
    end

`ifdef I2S_PORT_COUNTERS_EN
    // Saturating event counters; clear first so a coincident event still counts
    always_comb begin
        overrun_count_d  = clear_flags ? 16'h0000 : overrun_count_q;
        underrun_count_d = clear_flags ? 16'h0000 : underrun_count_q;
        if (ovr_set && overrun_count_d != 16'hFFFF)
            overrun_count_d = overrun_count_d + 16'h0001;
        if (und_set && underrun_count_d != 16'hFFFF)
            underrun_count_d = underrun_count_d + 16'h0001;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count_q  <= '0;
            underrun_count_q <= '0;
        end else begin
            overrun_count_q  <= overrun_count_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign overrun_count  = overrun_count_q;
    assign underrun_count = underrun_count_q;
`endif

    // State registers; reset returns everything, including the synchronisers, to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q    <= '0;
            lrclk_sync_q   <= '0;
            sdin_sync_q    <= '0;
            locked_q       <= 1'b0;
            bit_ctr_q      <= '0;
            rx_sr_q        <= '0;
            in_sample_q    <= '0;
            sample_ready_q <= 1'b0;
            state_q        <= ST_IDLE;
            ready_prev_q   <= 1'b0;
            tx_hold_q      <= '0;
            fresh_q        <= 1'b0;
            tx_sr_q        <= '0;
            sdout_q        <= 1'b0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            bclk_sync_q    <= bclk_sync_d;
            lrclk_sync_q   <= lrclk_sync_d;
            sdin_sync_q    <= sdin_sync_d;
            locked_q       <= locked_d;
            bit_ctr_q      <= bit_ctr_d;
            rx_sr_q        <= rx_sr_d;
            in_sample_q    <= in_sample_d;
            sample_ready_q <= sample_ready_d;
            state_q        <= state_d;
            ready_prev_q   <= ready_prev_d;
            tx_hold_q      <= tx_hold_d;
            fresh_q        <= fresh_d;
            tx_sr_q        <= tx_sr_d;
            sdout_q        <= sdout_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
        end
    end

    assign sdout        = sdout_q;
    assign in_sample    = in_sample_q;
    assign sample_ready = sample_ready_q;
    assign overrun      = overrun_q;
    assign underrun     = underrun_q;

endmodule
